// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Word-addressed data memory on the responder side of the core's
//   load/store port. Loads are combinational and stores commit on the rising
//   clock edge. An asynchronous active-low reset clears the array, the error
//   record and the counters. Address checking keeps a sticky record of the
//   first bad access. A debug peek port reads the array with no side effects.
//
// Optional feature macro: DMEM_ACCESS_CNT_EN
//   When defined, the block keeps saturating counts of valid loads and
//   stores. When undefined, both count outputs are tied to zero.
//
// Ports:
//   DMR_IN_CLK        rising-edge clock
//   DMR_IN_RST_N      asynchronous active-low reset
//   DMR_IN_ADDR       byte address from the core
//   DMR_IN_W_DATA     store data
//   DMR_IN_MEMWRITE   store strobe
//   DMR_IN_MEMREAD    load strobe
//   DMR_OUT_R_DATA    load data (combinational)
//   DMR_IN_DBG_ADDR   word index for the peek port
//   DMR_OUT_DBG_DATA  array content at DBG_ADDR (combinational)
//   DMR_OUT_ERR       sticky error flag
//   DMR_OUT_ERR_CODE  first error: 01 misaligned, 10 out of range, 11 both strobes
//   DMR_OUT_ERR_ADDR  address of the first error
//   DMR_OUT_RD_CNT    completed valid loads
//   DMR_OUT_WR_CNT    completed valid stores
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned R_g    = 8,
  parameter int unsigned C_g    = 32,
  parameter logic [31:0] BASE_g = 32'h1001_0000
) (
  input  logic                    DMR_IN_CLK,
  input  logic                    DMR_IN_RST_N,
  input  logic [31:0]             DMR_IN_ADDR,
  input  logic [C_g-1:0]          DMR_IN_W_DATA,
  input  logic                    DMR_IN_MEMWRITE,
  input  logic                    DMR_IN_MEMREAD,
  output logic [C_g-1:0]          DMR_OUT_R_DATA,
  input  logic [$clog2(R_g)-1:0]  DMR_IN_DBG_ADDR,
  output logic [C_g-1:0]          DMR_OUT_DBG_DATA,
  output logic                    DMR_OUT_ERR,
  output logic [1:0]              DMR_OUT_ERR_CODE,
  output logic [31:0]             DMR_OUT_ERR_ADDR,
  output logic [31:0]             DMR_OUT_RD_CNT,
  output logic [31:0]             DMR_OUT_WR_CNT
);

  localparam int unsigned AW = $clog2(R_g);

  logic [31:0]    offset_s;
  logic [AW-1:0]  index_s;
  logic           misaligned_s;
  logic           out_of_range_s;
  logic           valid_s;
  logic           both_s;
  logic           store_ok_s;
  logic           err_event_s;
  logic [1:0]     err_code_s;

  logic [C_g-1:0] mem_q [R_g];
  logic [C_g-1:0] mem_d [R_g];
  logic           err_q, err_d;
  logic [1:0]     err_code_q, err_code_d;
  logic [31:0]    err_addr_q, err_addr_d;

  // The offset wraps at 32 bits, so addresses below BASE_g land far out of
  // range rather than aliasing onto low words.
  assign offset_s       = DMR_IN_ADDR - BASE_g;
  assign index_s        = offset_s[AW+1:2];
  assign misaligned_s   = (offset_s[1:0] != 2'b00);
  assign out_of_range_s = (offset_s[31:AW+2] != {(32-AW-2){1'b0}});
  assign valid_s        = !misaligned_s && !out_of_range_s;
  assign both_s         = DMR_IN_MEMWRITE && DMR_IN_MEMREAD;
  assign store_ok_s     = DMR_IN_MEMWRITE && valid_s;
  assign err_event_s    = both_s || ((DMR_IN_MEMWRITE || DMR_IN_MEMREAD) && !valid_s);

  // Error classification: both strobes wins, then misaligned, then range.
  always_comb begin
    err_code_s = 2'b00;
    case ({both_s, misaligned_s})
      2'b10, 2'b11: err_code_s = 2'b11;
      2'b01:        err_code_s = 2'b01;
      2'b00:        err_code_s = 2'b10;
      default:      err_code_s = 2'b00;
    endcase
  end

  // Next-state for the array and the first-error record.
  always_comb begin
    mem_d      = mem_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    if (store_ok_s) begin
      mem_d[index_s] = DMR_IN_W_DATA;
    end else begin
      mem_d = mem_q;
    end
    if (!err_q && err_event_s) begin
      err_d      = 1'b1;
      err_code_d = err_code_s;
      err_addr_d = DMR_IN_ADDR;
    end else begin
      err_d      = err_q;
    end
  end

  // Array and error-record state, cleared asynchronously by reset.
  always_ff @(posedge DMR_IN_CLK or negedge DMR_IN_RST_N) begin
    if (!DMR_IN_RST_N) begin
      for (int i = 0; i < int'(R_g); i++) begin
        mem_q[i] <= {C_g{1'b0}};
      end
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      err_addr_q <= 32'h0000_0000;
    end else begin
      mem_q      <= mem_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Load data returns the pre-store content even in a both-strobe cycle.
  always_comb begin
    DMR_OUT_R_DATA = {C_g{1'b0}};
    if (DMR_IN_RST_N && DMR_IN_MEMREAD && valid_s) begin
      DMR_OUT_R_DATA = mem_q[index_s];
    end else begin
      DMR_OUT_R_DATA = {C_g{1'b0}};
    end
  end

  // Peek port, forced to zero while reset is held.
  always_comb begin
    DMR_OUT_DBG_DATA = {C_g{1'b0}};
    if (DMR_IN_RST_N) begin
      DMR_OUT_DBG_DATA = mem_q[DMR_IN_DBG_ADDR];
    end else begin
      DMR_OUT_DBG_DATA = {C_g{1'b0}};
    end
  end

  assign DMR_OUT_ERR      = err_q;
  assign DMR_OUT_ERR_CODE = err_code_q;
  assign DMR_OUT_ERR_ADDR = err_addr_q;

`ifdef DMEM_ACCESS_CNT_EN
  logic        load_ok_s;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // A both-strobe cycle never counts as a load.
  assign load_ok_s = DMR_IN_MEMREAD && !DMR_IN_MEMWRITE && valid_s;

  // Saturating counter next-state.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (load_ok_s && (rd_cnt_q != 32'hFFFF_FFFF)) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
    if (store_ok_s && (wr_cnt_q != 32'hFFFF_FFFF)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge DMR_IN_CLK or negedge DMR_IN_RST_N) begin
    if (!DMR_IN_RST_N) begin
      rd_cnt_q <= 32'h0000_0000;
      wr_cnt_q <= 32'h0000_0000;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign DMR_OUT_RD_CNT = rd_cnt_q;
  assign DMR_OUT_WR_CNT = wr_cnt_q;
`else
  assign DMR_OUT_RD_CNT = 32'h0000_0000;
  assign DMR_OUT_WR_CNT = 32'h0000_0000;
`endif

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data memory that answers the RISC_V core's data port: combinational reads, writes committed on the rising clock edge. It replaces the behavioural data memory model on the responder side of the core's load/store interface, adding reset-clear, address checking with a sticky error record, and a debug peek port for the bench. Optional access counters are compiled in by macro.

## Interface
Parameters:
- R_g, 8, number of 32-bit words (power of two, 2..1024)
- C_g, 32, word width in bits (fixed at 32 for the core)
- BASE_g, 32'h1001_0000, byte address of word 0

Ports:
- DMR_IN_CLK  in  1  clock, rising edge
- DMR_IN_RST_N  in  1  reset, asynchronous, active-low
- DMR_IN_ADDR  in  32  byte address from core
- DMR_IN_W_DATA  in  32  store data
- DMR_IN_MEMWRITE  in  1  store strobe
- DMR_IN_MEMREAD  in  1  load strobe
- DMR_OUT_R_DATA  out  32  load data
- DMR_IN_DBG_ADDR  in  log2(R_g)  word index for bench peek
- DMR_OUT_DBG_DATA  out  32  array content at DBG_ADDR (combinational)
- DMR_OUT_ERR  out  1  sticky error flag
- DMR_OUT_ERR_CODE  out  2  first error: 01 misaligned, 10 out of range, 11 both strobes
- DMR_OUT_ERR_ADDR  out  32  address of first error
- DMR_OUT_RD_CNT  out  32  completed valid loads
- DMR_OUT_WR_CNT  out  32  completed valid stores

## Operation
- Offset = ADDR − BASE_g (32-bit wrap); index = offset[log2(R_g)+1:2].
- Access valid iff offset[1:0]==0 and offset>>2 < R_g. Misaligned takes priority over out of range for coding.
- Load (MEMREAD=1, MEMWRITE=0): valid → R_DATA = array[index]; invalid → R_DATA = 0, error event.
- Store (MEMWRITE=1, MEMREAD=0): valid → array[index] ← W_DATA at edge; invalid → array unchanged, error event.
- Both strobes high: store performed if address valid; R_DATA returns pre-store content; error event code 11 regardless of address.
- Neither strobe: R_DATA = 0, no state change.
- Error record: on first error event after reset, ERR←1, ERR_CODE and ERR_ADDR captured at the edge; later events do not overwrite. Cleared only by reset.
- DBG port reads the array independently of core traffic; no side effects.

## Timing
- Reset asserted: all array words, ERR, ERR_CODE, ERR_ADDR, counters → 0 immediately; R_DATA = 0 and DBG_DATA = 0 while reset held.
- Load latency 0 cycles (combinational from ADDR/MEMREAD).
- Store visible to loads and DBG port from the cycle after the committing edge; a same-cycle load of the stored address returns old data.
- Strobes sampled only at rising edge for state updates; glitches between edges have no effect.
- Reset asserted in the same cycle as a store: store lost, array reads 0.
- Reset release: first edge with RST_N=1 is a normal operating edge.

## Configuration
- DMEM_ACCESS_CNT_EN defined: RD_CNT/WR_CNT increment by 1 at each edge with a valid load/store respectively (both-strobe cycle counts the store only if valid, never the load); saturate at 32'hFFFF_FFFF.
- Not defined: counter registers absent; RD_CNT and WR_CNT tied to 0. Ports exist in both builds.

## Test plan
- Reset then load 0x1001_0004 → R_DATA=0, ERR=0; DBG_ADDR=1 → DBG_DATA=0.
- Store 0xDEAD_BEEF to 0x1001_0008, load same next cycle → R_DATA=0xDEAD_BEEF; same-cycle load during store returned 0; WR_CNT=1, RD_CNT=1 (macro on) or 0/0 (off).
- Load 0x1001_0006 → R_DATA=0, ERR=1, ERR_CODE=01, ERR_ADDR=0x1001_0006; then store to 0x1001_0020 (R_g=8) → array unchanged, code stays 01.
- Both strobes at 0x1001_0000, W_DATA=0x1234_5678 with word 0 = 0xA5A5_A5A5 → R_DATA=0xA5A5_A5A5 that cycle, word 0=0x1234_5678 after, ERR_CODE=11.
- Store 0xFFFF_FFFF to word 7, assert RST_N=0 mid-cycle → DBG word 7=0, ERR=0, counters 0 asynchronously.
- Macro on: force WR_CNT to 0xFFFF_FFFE, two valid stores → WR_CNT=0xFFFF_FFFF held.
